restoring_divider_seq: RTL and testbench

//   Parametrised multi-cycle restoring divider, one quotient bit per clock, MSB first.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 30 +++
 rtl/restoring_divider_seq.sv | 160 ++++++++++++++++
 tb/tb_restoring_divider_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider family: FSM state encoding
// and the step-counter width helper.
package div_pkg;

    // Divider control states. The debug port carries this type directly.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Counter width for the reference 8-bit dividend.
    localparam int DIV_COUNT_W = $clog2(8);

    // Counter width needed to count DIVIDEND_W restoring steps (0 .. W-1).
    function automatic int div_count_w(input int dividend_w);
        return (dividend_w > 1) ? $clog2(dividend_w) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and keep the difference
// only when it does not go negative. Purely combinational.
module div_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W-1:0] rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] trial;
    logic [DIVISOR_W:0] diff;
    logic               unused_msbs;

    // Shift, compare, conditionally subtract. The partial remainder always
    // stays below the divisor, so the result fits back into DIVISOR_W bits.
    always_comb begin
        trial   = {rem_in, bit_in};
        diff    = trial - {1'b0, divisor};
        q_bit   = (trial >= {1'b0, divisor});
        rem_out = q_bit ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
    end

    // The top bits of trial/diff are always zero whenever they are selected.
    assign unused_msbs = diff[DIVISOR_W] ^ trial[DIVISOR_W];

endmodule

// File: rtl/restoring_divider_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock, MSB first.
// Optional build macro: SIGNED_DIV_EN (two's-complement operands/results,
// truncating quotient, remainder follows the dividend sign).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high in IDLE, or in DONE while out_ready is high,
// so a finished result can retire and new operands can be taken on the same
// edge. out_valid is high exactly in DONE and the result is held stable
// until out_ready is seen.
module restoring_divider_seq
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output div_state_t            dbg_state
);

    localparam int             CW        = div_count_w(DIVIDEND_W);
    localparam logic [CW-1:0]  LAST_STEP = CW'(DIVIDEND_W - 1);

    div_state_t            state;
    logic [DIVIDEND_W-1:0] q_sr;       // remaining dividend bits, quotient shifts in at LSB
    logic [DIVISOR_W-1:0]  rem_r;      // partial remainder
    logic [DIVISOR_W-1:0]  divisor_r;  // latched divisor magnitude
    logic [CW-1:0]         count;
    logic                  dz_r;       // accepted operation has a zero divisor

    logic                  accept;
    logic [DIVIDEND_W-1:0] dvd_mag;
    logic [DIVISOR_W-1:0]  dvs_mag;
    logic [DIVISOR_W-1:0]  step_rem;
    logic                  step_q;
    logic [DIVIDEND_W-1:0] q_raw;
    logic [DIVIDEND_W-1:0] q_final;
    logic [DIVISOR_W-1:0]  r_final;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;
    assign q_raw     = {q_sr[DIVIDEND_W-2:0], step_q};

    div_step #(
        .DIVISOR_W(DIVISOR_W)
    ) u_step (
        .rem_in (rem_r),
        .bit_in (q_sr[DIVIDEND_W-1]),
        .divisor(divisor_r),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

`ifdef SIGNED_DIV_EN
    localparam logic [DIVIDEND_W-1:0] DVD_ONE = 1;
    localparam logic [DIVISOR_W-1:0]  DVS_ONE = 1;

    logic neg_q_r;
    logic neg_r_r;

    // Magnitudes into the unsigned core; sign restoration on the final step.
    // The most negative dividend over -1 gives magnitude 2^(W-1) with a
    // positive sign, which reads back as the unchanged dividend.
    always_comb begin
        dvd_mag = dividend[DIVIDEND_W-1] ? (~dividend + DVD_ONE) : dividend;
        dvs_mag = divisor[DIVISOR_W-1]   ? (~divisor + DVS_ONE)  : divisor;
        q_final = neg_q_r ? (~q_raw + DVD_ONE)    : q_raw;
        r_final = neg_r_r ? (~step_rem + DVS_ONE) : step_rem;
    end

    // Result signs captured with the operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (accept) begin
            neg_q_r <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            neg_r_r <= dividend[DIVIDEND_W-1];
        end
    end
`else
    // Unsigned build: operands and results pass straight through.
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
        q_final = q_raw;
        r_final = step_rem;
    end
`endif

    // Control FSM with the iteration datapath and registered results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            q_sr        <= '0;
            rem_r       <= '0;
            divisor_r   <= '0;
            count       <= '0;
            dz_r        <= 1'b0;
        end else if (accept) begin
            state     <= RUN;
            out_valid <= 1'b0;
            q_sr      <= dvd_mag;
            rem_r     <= '0;
            divisor_r <= dvs_mag;
            count     <= '0;
            dz_r      <= (divisor == '0);
        end else begin
            case (state)
                IDLE: begin
                end
                RUN: begin
                    if (dz_r) begin
                        // Zero divisor: no iterations, fixed result one edge later.
                        quotient    <= '1;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        rem_r <= step_rem;
                        q_sr  <= q_raw;
                        count <= count + CW'(1);
                        if (count == LAST_STEP) begin
                            quotient    <= q_final;
                            remainder   <= r_final;
                            div_by_zero <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Self-checking bench for restoring_divider_seq (8-bit dividend, 4-bit divisor).
// Build with SIGNED_DIV_EN defined to exercise the signed variant.
module tb_restoring_divider_seq;

    localparam int DW = 8;
    localparam int VW = 4;
    localparam int EW = DW + VW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DW-1:0]        dividend = '0;
    logic [VW-1:0]        divisor = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [DW-1:0]        quotient;
    logic [VW-1:0]        remainder;
    logic                 div_by_zero;
    div_pkg::div_state_t  dbg_state;

    restoring_divider_seq #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: {quotient, remainder, div_by_zero}.
    function automatic logic [EW-1:0] model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        logic [DW-1:0] q;
        logic [DW-1:0] r;
`ifdef SIGNED_DIV_EN
        int sa;
        int sb;
        int sq;
        int sr;
`endif
        if (b == '0) return {{DW{1'b1}}, {VW{1'b0}}, 1'b1};
`ifdef SIGNED_DIV_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
        sq = sa / sb;
        sr = sa % sb;
        q  = sq[DW-1:0];
        r  = sr[DW-1:0];
`else
        q = a / DW'(b);
        r = a % DW'(b);
`endif
        return {q, r[VW-1:0], 1'b0};
    endfunction

    // ---------------- driver tasks ----------------
    // Present operands, wait for in_ready, complete the transfer on the next edge.
    task automatic drive_op(input logic [DW-1:0] a, input logic [VW-1:0] b);
        int guard = 0;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
        end else begin
            exp_q.push_back(model(a, b));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL out_valid_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        n_checks++;
        if (quotient !== '0) begin n_fail++; $display("FAIL reset_quotient: got %0h required 0", quotient); end
        n_checks++;
        if (remainder !== '0) begin n_fail++; $display("FAIL reset_remainder: got %0h required 0", remainder); end
        n_checks++;
        if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_by_zero: got %0b required 0", div_by_zero); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        n_checks++;
        if (dbg_state !== div_pkg::IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required IDLE", dbg_state); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_unsigned_table();
        logic [DW-1:0] ta[6] = '{8'd200, 8'd7, 8'd255, 8'd0, 8'd255, 8'd128};
        logic [VW-1:0] tb[6] = '{4'd7, 4'd9, 4'd1, 4'd15, 4'd15, 4'd2};
        int lat;
        logic [EW-1:0] exp;
        for (int i = 0; i < 6; i++) begin
            drive_op(ta[i], tb[i]);
            wait_out(lat);
            n_checks++;
            if (lat !== DW) begin n_fail++; $display("FAIL table_latency[%0d]: got %0d required %0d", i, lat, DW); end
            exp = exp_q.pop_front();
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== exp) begin
                n_fail++;
                $display("FAIL table_result[%0d] %0d/%0d: got q=%0h r=%0h dz=%0b required q=%0h r=%0h dz=%0b",
                         i, ta[i], tb[i], quotient, remainder, div_by_zero, exp[EW-1 -: DW], exp[VW:1], exp[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_zero();
        logic [DW-1:0] ta[2] = '{8'd5, 8'd0};
        int lat;
        logic [EW-1:0] exp;
        for (int i = 0; i < 2; i++) begin
            drive_op(ta[i], '0);
            wait_out(lat);
            n_checks++;
            if (lat !== 1) begin n_fail++; $display("FAIL dz_latency[%0d]: got %0d required 1", i, lat); end
            exp = exp_q.pop_front();
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== exp) begin
                n_fail++;
                $display("FAIL dz_result[%0d]: got q=%0h r=%0h dz=%0b required q=%0h r=%0h dz=%0b",
                         i, quotient, remainder, div_by_zero, exp[EW-1 -: DW], exp[VW:1], exp[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [EW-1:0] exp;
        logic [DW-1:0] q_hold;
        logic [VW-1:0] r_hold;
        out_ready = 1'b0;
        drive_op(8'd100, 4'd3);
        wait_out(lat);
        exp = exp_q.pop_front();
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== exp) begin
            n_fail++;
            $display("FAIL bp_result: got q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                     quotient, remainder, div_by_zero, exp[EW-1 -: DW], exp[VW:1], exp[0]);
        end
        q_hold = exp[EW-1 -: DW];
        r_hold = exp[VW:1];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || quotient !== q_hold || remainder !== r_hold) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%0b q=%0d r=%0d required v=1 q=%0d r=%0d",
                         i, out_valid, quotient, remainder, q_hold, r_hold);
            end
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b required 0", i, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %0b required 1", in_ready); end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_retire: out_valid got %0b required 0", out_valid); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen_valid = 0;
        logic [EW-1:0] exp;
        drive_op(8'd200, 4'd7);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if (out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs: got v=%0b q=%0h r=%0h dz=%0b required all 0",
                     out_valid, quotient, remainder, div_by_zero);
        end
        n_checks++;
        if (dbg_state !== div_pkg::IDLE) begin n_fail++; $display("FAIL midrun_reset_state: got %0d required IDLE", dbg_state); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen_valid++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen_valid !== 0) begin n_fail++; $display("FAIL midrun_no_valid: out_valid seen %0d cycles required 0", seen_valid); end
        drive_op(8'd9, 4'd2);
        wait_out(lat);
        exp = exp_q.pop_front();
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== exp) begin
            n_fail++;
            $display("FAIL midrun_after_result: got q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                     quotient, remainder, div_by_zero, exp[EW-1 -: DW], exp[VW:1], exp[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        int guard = 0;
        logic [EW-1:0] exp;
        dividend = 8'd200;
        divisor  = 4'd7;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        exp_q.push_back(model(8'd200, 4'd7));
        // Operands change while busy; they must be ignored until DONE.
        dividend = 8'd50;
        divisor  = 4'd5;
        exp_q.push_back(model(8'd50, 4'd5));
        wait_out(lat);
        n_checks++;
        if (lat !== DW) begin n_fail++; $display("FAIL b2b_latency0: got %0d required %0d", lat, DW); end
        exp = exp_q.pop_front();
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== exp) begin
            n_fail++;
            $display("FAIL b2b_result0: got q=%0d r=%0d required q=%0d r=%0d", quotient, remainder, exp[EW-1 -: DW], exp[VW:1]);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %0b required 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || dbg_state !== div_pkg::RUN) begin
            n_fail++;
            $display("FAIL b2b_reaccept: got v=%0b state=%0d required v=0 state=RUN", out_valid, dbg_state);
        end
        wait_out(lat);
        n_checks++;
        if (lat !== DW) begin n_fail++; $display("FAIL b2b_latency1: got %0d required %0d", lat, DW); end
        exp = exp_q.pop_front();
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== exp) begin
            n_fail++;
            $display("FAIL b2b_result1: got q=%0d r=%0d required q=%0d r=%0d", quotient, remainder, exp[EW-1 -: DW], exp[VW:1]);
        end
        @(posedge clk); #1;
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        logic [DW-1:0] ta[3] = '{8'h9C, 8'h80, 8'h64};
        logic [VW-1:0] tb[3] = '{4'd7, 4'hF, 4'hD};
        int lat;
        logic [EW-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive_op(ta[i], tb[i]);
            wait_out(lat);
            exp = exp_q.pop_front();
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== exp) begin
                n_fail++;
                $display("FAIL signed_result[%0d]: got q=%0h r=%0h dz=%0b required q=%0h r=%0h dz=%0b",
                         i, quotient, remainder, div_by_zero, exp[EW-1 -: DW], exp[VW:1], exp[0]);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    task automatic test_random();
        int lat;
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [EW-1:0] exp;
        for (int i = 0; i < 40; i++) begin
            a = DW'($urandom_range(0, 255));
            b = VW'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            drive_op(a, b);
            wait_out(lat);
            n_checks++;
            if (lat !== ((b == '0) ? 1 : DW)) begin
                n_fail++;
                $display("FAIL rand_latency[%0d] %0d/%0d: got %0d", i, a, b, lat);
            end
            exp = exp_q.pop_front();
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== exp) begin
                n_fail++;
                $display("FAIL rand_result[%0d] %0h/%0h: got q=%0h r=%0h dz=%0b required q=%0h r=%0h dz=%0b",
                         i, a, b, quotient, remainder, div_by_zero, exp[EW-1 -: DW], exp[VW:1], exp[0]);
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_unsigned_table();
        test_div_zero();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        test_random();
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
